// File: rtl/pulse_gen_multi.sv
// N-channel edge-to-pulse generator: per channel a synchroniser, a debouncer, edge detection
// and a PULSE/GAP state machine with a one-deep pending slot and a sticky loss flag.
module pulse_gen_multi #(
  parameter int N           = 1,
  parameter int SYNC_STAGES = 0,
  parameter int DEBOUNCE    = 1,
  parameter int MODE        = 0,
  parameter int PULSE_LEN   = 1,
  parameter int GAP_LEN     = 0,
  parameter int RETRIGGER   = 0
) (
  input  logic         CLK,
  input  logic         reset_n,
  input  logic [N-1:0] x,
  input  logic [N-1:0] en,
  input  logic         clr_lost,
  output logic [N-1:0] y,
  output logic [N-1:0] level,
  output logic [N-1:0] busy,
  output logic [N-1:0] lost
);

  localparam int CW   = $clog2(DEBOUNCE + 1);
  localparam int PMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE - 1);
  localparam logic [PW-1:0] PULSE_INIT = PW'(PULSE_LEN - 1);
  localparam logic [PW-1:0] GAP_INIT   = (GAP_LEN > 0) ? PW'(GAP_LEN - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_ch
      logic          xs;
      logic          lvl_q;
      logic [CW-1:0] dcnt;
      logic          flip;
      logic          edge_ok;
      logic          ev;
      logic          pend_rule;
      logic          lost_set;
      state_t        state;
      logic [PW-1:0] pcnt;
      logic          pending;
      logic          y_q;
      logic          busy_q;
      logic          lost_q;

      if (SYNC_STAGES == 0) begin : g_nosync
        assign xs = x[g];
      end else begin : g_sync
        logic [SYNC_STAGES-1:0] sff;
        always_ff @(posedge CLK) begin
          if (!reset_n) begin
            sff <= '0;
          end else begin
            sff[0] <= x[g];
            for (int k = 1; k < SYNC_STAGES; k++) sff[k] <= sff[k-1];
          end
        end
        assign xs = sff[SYNC_STAGES-1];
      end

      // Debounce: level follows xs only after DEBOUNCE consecutive differing samples
      always_ff @(posedge CLK) begin
        if (!reset_n) begin
          lvl_q <= 1'b0;
          dcnt  <= '0;
        end else if (xs != lvl_q) begin
          if (dcnt == DB_LAST) begin
            lvl_q <= xs;
            dcnt  <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end else begin
          dcnt <= '0;
        end
      end

      always_comb begin
        flip    = (xs != lvl_q) && (dcnt == DB_LAST);
        edge_ok = (MODE == 2) ? 1'b1 : ((MODE == 0) ? xs : ~xs);
        ev      = flip & edge_ok & en[g];
        // Edges that land on a terminal count which re-enters PULSE are consumed, not queued
        pend_rule = ((state == PULSE) && (RETRIGGER == 0) && ((pcnt != '0) || (GAP_LEN > 0)))
                 || ((state == GAP) && (pcnt != '0));
        lost_set  = ev & pend_rule & pending;
      end

      always_ff @(posedge CLK) begin
        if (!reset_n) begin
          state   <= IDLE;
          pcnt    <= '0;
          pending <= 1'b0;
          y_q     <= 1'b0;
          busy_q  <= 1'b0;
          lost_q  <= 1'b0;
        end else begin
          lost_q <= lost_set | (lost_q & ~clr_lost);
          if (!en[g]) begin
            state   <= IDLE;
            pcnt    <= '0;
            pending <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            case (state)
              IDLE: begin
                if (ev) begin
                  state  <= PULSE;
                  pcnt   <= PULSE_INIT;
                  y_q    <= 1'b1;
                  busy_q <= 1'b1;
                end
              end
              PULSE: begin
                if (ev && (RETRIGGER != 0)) begin
                  pcnt <= PULSE_INIT;
                end else if (pcnt != '0) begin
                  pcnt <= pcnt - 1'b1;
                  if (ev) pending <= 1'b1;
                end else if (GAP_LEN > 0) begin
                  state <= GAP;
                  pcnt  <= GAP_INIT;
                  y_q   <= 1'b0;
                  if (ev) pending <= 1'b1;
                end else if (pending || ev) begin
                  pcnt    <= PULSE_INIT;
                  pending <= 1'b0;
                end else begin
                  state  <= IDLE;
                  y_q    <= 1'b0;
                  busy_q <= 1'b0;
                end
              end
              GAP: begin
                if (pcnt != '0) begin
                  pcnt <= pcnt - 1'b1;
                  if (ev) pending <= 1'b1;
                end else if (pending || ev) begin
                  state   <= PULSE;
                  pcnt    <= PULSE_INIT;
                  pending <= 1'b0;
                  y_q     <= 1'b1;
                end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                end
              end
              default: begin
                state  <= IDLE;
                y_q    <= 1'b0;
                busy_q <= 1'b0;
              end
            endcase
          end
        end
      end

      assign y[g]     = y_q;
      assign level[g] = lvl_q;
      assign busy[g]  = busy_q;
      assign lost[g]  = lost_q;
    end
  endgenerate

endmodule
